// File: rtl/mvm_pkg.sv
// ============================================================================
// Module : mvm_pkg
// Brief  : Shared MVM command-type codes, sideband layout and helpers
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mvm_pkg;

    localparam int NUM_DPES    = 64;
    localparam int DPE_W       = 7;
    localparam int RF_ADDR_W   = 9;
    localparam int TYPE_W      = 2;
    localparam int INSTR_W     = 32;

    localparam int RF_ADDR_LSB = 0;
    localparam int TYPE_LSB    = 9;
    localparam int RF_EN_LSB   = 11;
    localparam int SIDEBAND_W  = RF_EN_LSB + NUM_DPES;

    localparam logic [TYPE_W-1:0] TYPE_WEIGHT = 2'b11;
    localparam logic [TYPE_W-1:0] TYPE_INSTR  = 2'b00;

    typedef enum logic {
        CMD_INSTR  = 1'b0,
        CMD_WEIGHT = 1'b1
    } cmd_kind_e;

    // Top DPE bit selects a broadcast to every register file.
    function automatic logic [NUM_DPES-1:0] dpe_rf_en(input logic [DPE_W-1:0] dpe);
        logic [NUM_DPES-1:0] en;
        if (dpe[DPE_W-1]) begin
            en = '1;
        end else begin
            en = {{(NUM_DPES-1){1'b0}}, 1'b1} << dpe[DPE_W-2:0];
        end
        return en;
    endfunction

    function automatic logic [SIDEBAND_W-1:0] build_sideband(
        input cmd_kind_e              kind,
        input logic [RF_ADDR_W-1:0]   rf_addr,
        input logic [DPE_W-1:0]       dpe
    );
        logic [SIDEBAND_W-1:0] sb;
        sb = '0;
        if (kind == CMD_WEIGHT) begin
            sb[RF_ADDR_LSB +: RF_ADDR_W] = rf_addr;
            sb[TYPE_LSB    +: TYPE_W]    = TYPE_WEIGHT;
            sb[RF_EN_LSB   +: NUM_DPES]  = dpe_rf_en(dpe);
        end else begin
            sb[TYPE_LSB    +: TYPE_W]    = TYPE_INSTR;
        end
        return sb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_fifo.sv
// ============================================================================
// Module : cfg_fifo
// Brief  : Show-ahead synchronous FIFO with registered wrap-bit pointers
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mvm_config_tx.sv
// ============================================================================
// Module : mvm_config_tx
// Brief  : Queues MVM weight/instruction commands and emits formatted AXIS beats
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvm_config_tx
    import mvm_pkg::*;
#(
    parameter int DATAW      = 512,
    parameter int USERW      = 75,
    parameter int IDW        = 2,
    parameter int DESTW      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cmd_wen,
    output logic                   cmd_rdy,
    input  logic                   cmd_is_weight,
    input  logic [DATAW-1:0]       cmd_data,
    input  logic [DPE_W-1:0]       cmd_dpe,
    input  logic [RF_ADDR_W-1:0]   cmd_rf_addr,
    input  logic [DESTW-1:0]       cmd_dest,
    input  logic                   cmd_last,

    output logic                   axis_tx_tvalid,
    input  logic                   axis_tx_tready,
    output logic [DATAW+USERW-1:0] axis_tx_tdata,
    output logic [IDW-1:0]         axis_tx_tid,
    output logic [DESTW-1:0]       axis_tx_tdest,
    output logic                   axis_tx_tlast,

    output logic [31:0]            sent_count,
    output logic                   overflow
);

    localparam int ENTRY_W  = DATAW + 1 + DPE_W + RF_ADDR_W + DESTW + 1;
    localparam int WGT_BIT  = DATAW;
    localparam int DPE_LSB  = WGT_BIT + 1;
    localparam int RF_LSB   = DPE_LSB + DPE_W;
    localparam int DEST_LSB = RF_LSB + RF_ADDR_W;
    localparam int LAST_BIT = DEST_LSB + DESTW;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [ENTRY_W-1:0]     fifo_wdata;
    logic [ENTRY_W-1:0]     fifo_head;

    logic [DATAW-1:0]       head_data;
    logic                   head_is_weight;
    logic [DPE_W-1:0]       head_dpe;
    logic [RF_ADDR_W-1:0]   head_rf_addr;
    logic [DESTW-1:0]       head_dest;
    logic                   head_last;

    logic [DATAW-1:0]       beat_payload;
    logic [USERW-1:0]       beat_user;
    logic                   load;
    logic                   handshake;

    logic                   tvalid_q, tvalid_d;
    logic [DATAW+USERW-1:0] tdata_q, tdata_d;
    logic [DESTW-1:0]       tdest_q, tdest_d;
    logic                   tlast_q, tlast_d;
    logic [31:0]            sent_count_q, sent_count_d;
    logic                   overflow_q, overflow_d;

    // Raw command fields are queued; formatting happens on the way out.
    assign fifo_wdata = {cmd_last, cmd_dest, cmd_rf_addr, cmd_dpe, cmd_is_weight, cmd_data};

    cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_cfg_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (cmd_wen),
        .wr_data_i (fifo_wdata),
        .full_o    (fifo_full),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty)
    );

    assign head_data      = fifo_head[DATAW-1:0];
    assign head_is_weight = fifo_head[WGT_BIT];
    assign head_dpe       = fifo_head[DPE_LSB +: DPE_W];
    assign head_rf_addr   = fifo_head[RF_LSB +: RF_ADDR_W];
    assign head_dest      = fifo_head[DEST_LSB +: DESTW];
    assign head_last      = fifo_head[LAST_BIT];

    assign cmd_rdy   = !fifo_full;
    assign handshake = tvalid_q && axis_tx_tready;
    assign load      = !fifo_empty && (!tvalid_q || axis_tx_tready);
    assign fifo_pop  = load;

    always_comb begin
        beat_payload = '0;
        beat_user    = '0;
        if (head_is_weight) begin
            beat_payload = head_data;
        end else begin
            beat_payload[INSTR_W-1:0] = head_data[INSTR_W-1:0];
        end
        beat_user[SIDEBAND_W-1:0] = build_sideband(cmd_kind_e'(head_is_weight),
                                                   head_rf_addr, head_dpe);
    end

    always_comb begin
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tdest_d      = tdest_q;
        tlast_d      = tlast_q;
        sent_count_d = sent_count_q;
        overflow_d   = overflow_q | (cmd_wen & fifo_full);
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = {beat_user, beat_payload};
            tdest_d  = head_dest;
            tlast_d  = head_last;
        end else if (axis_tx_tready) begin
            tvalid_d = 1'b0;
        end
        if (handshake) begin
            sent_count_d = sent_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tdest_q      <= '0;
            tlast_q      <= 1'b0;
            sent_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tdest_q      <= tdest_d;
            tlast_q      <= tlast_d;
            sent_count_q <= sent_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign axis_tx_tvalid = tvalid_q;
    assign axis_tx_tdata  = tdata_q;
    assign axis_tx_tdest  = tdest_q;
    assign axis_tx_tlast  = tlast_q;
    assign axis_tx_tid    = '0;
    assign sent_count     = sent_count_q;
    assign overflow       = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_mvm_config_tx.sv
// ============================================================================
// Module : tb_mvm_config_tx
// Brief  : Self-checking bench for mvm_config_tx against a queue-based model
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvm_config_tx;

    localparam int DW = 512;
    localparam int UW = 75;
    localparam int IW = 2;
    localparam int TW = 4;
    localparam int FD = 8;
    localparam int BW = DW + UW;

    typedef struct packed {
        logic          w;
        logic [DW-1:0] data;
        logic [6:0]    dpe;
        logic [8:0]    rf;
        logic [TW-1:0] dest;
        logic          last;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_wen;
    logic          cmd_rdy;
    logic          cmd_is_weight;
    logic [DW-1:0] cmd_data;
    logic [6:0]    cmd_dpe;
    logic [8:0]    cmd_rf_addr;
    logic [TW-1:0] cmd_dest;
    logic          cmd_last;
    logic          axis_tx_tvalid;
    logic          axis_tx_tready;
    logic [BW-1:0] axis_tx_tdata;
    logic [IW-1:0] axis_tx_tid;
    logic [TW-1:0] axis_tx_tdest;
    logic          axis_tx_tlast;
    logic [31:0]   sent_count;
    logic          overflow;

    mvm_config_tx #(
        .DATAW      (DW),
        .USERW      (UW),
        .IDW        (IW),
        .DESTW      (TW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_wen        (cmd_wen),
        .cmd_rdy        (cmd_rdy),
        .cmd_is_weight  (cmd_is_weight),
        .cmd_data       (cmd_data),
        .cmd_dpe        (cmd_dpe),
        .cmd_rf_addr    (cmd_rf_addr),
        .cmd_dest       (cmd_dest),
        .cmd_last       (cmd_last),
        .axis_tx_tvalid (axis_tx_tvalid),
        .axis_tx_tready (axis_tx_tready),
        .axis_tx_tdata  (axis_tx_tdata),
        .axis_tx_tid    (axis_tx_tid),
        .axis_tx_tdest  (axis_tx_tdest),
        .axis_tx_tlast  (axis_tx_tlast),
        .sent_count     (sent_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int            n_cmp  = 0;
    int            n_fail = 0;
    int            n_beats = 0;
    cmd_t          exp_q[$];
    logic [31:0]   n_sent = '0;
    logic          ovf_m = 1'b0;
    logic          stall_prev = 1'b0;
    logic [BW-1:0] stall_data;
    logic [TW-1:0] stall_dest;
    logic          stall_last;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Beat layout from the command rules: sideband = {rf_en, type, rf_addr} above payload.
    function automatic logic [BW-1:0] exp_beat(input cmd_t c);
        logic [63:0] en;
        if (c.w) begin
            en = c.dpe[6] ? {64{1'b1}} : (64'd1 << c.dpe[5:0]);
            return {en, 2'b11, c.rf, c.data};
        end
        return {75'd0, 480'd0, c.data[31:0]};
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        for (int i = 0; i < DW / 32; i++) c.data[i*32 +: 32] = $urandom;
        c.w    = 1'($urandom_range(0, 1));
        c.dpe  = {($urandom_range(0, 7) == 0), 6'($urandom)};
        c.rf   = 9'($urandom);
        c.dest = TW'($urandom);
        c.last = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // One clock: drive at posedge+1, score at negedge, return at next posedge+1.
    task automatic cycle(input logic wen, input cmd_t c, input logic rdy, output logic acc);
        int held;
        cmd_wen        = wen;
        cmd_is_weight  = c.w;
        cmd_data       = c.data;
        cmd_dpe        = c.dpe;
        cmd_rf_addr    = c.rf;
        cmd_dest       = c.dest;
        cmd_last       = c.last;
        axis_tx_tready = rdy;
        @(negedge clk);
        held = exp_q.size();
        chk("sent_count", sent_count, n_sent);
        chk("overflow", overflow, ovf_m);
        if (stall_prev) begin
            chk("stall_tvalid", axis_tx_tvalid, 1);
            chk("stall_tdata", axis_tx_tdata, stall_data);
            chk("stall_tdest", axis_tx_tdest, stall_dest);
            chk("stall_tlast", axis_tx_tlast, stall_last);
        end
        if (held < FD)      chk("cmd_rdy_free", cmd_rdy, 1);
        else if (held > FD) chk("cmd_rdy_full", cmd_rdy, 0);
        if (axis_tx_tvalid && axis_tx_tready) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("beat_tdata", axis_tx_tdata, exp_beat(exp_q[0]));
                chk("beat_tdest", axis_tx_tdest, exp_q[0].dest);
                chk("beat_tlast", axis_tx_tlast, exp_q[0].last);
                chk("beat_tid", axis_tx_tid, 0);
                void'(exp_q.pop_front());
            end
            n_sent = n_sent + 32'd1;
            n_beats++;
        end
        acc = wen && cmd_rdy;
        if (acc) exp_q.push_back(c);
        if (wen && !cmd_rdy) ovf_m = 1'b1;
        stall_prev = axis_tx_tvalid && !axis_tx_tready;
        stall_data = axis_tx_tdata;
        stall_dest = axis_tx_tdest;
        stall_last = axis_tx_tlast;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        logic acc;
        cmd_t idle;
        int   guard;
        idle  = '0;
        guard = 0;
        while ((exp_q.size() != 0 || axis_tx_tvalid) && guard < 60) begin
            cycle(1'b0, idle, 1'b1, acc);
            guard++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        cmd_t c;
        cmd_t idle;
        logic acc;
        int   beats0;
        int   pushed;
        int   guard;
        logic [31:0] sent0;

        idle           = '0;
        rst            = 1'b1;
        cmd_wen        = 1'b0;
        cmd_is_weight  = 1'b0;
        cmd_data       = '0;
        cmd_dpe        = '0;
        cmd_rf_addr    = '0;
        cmd_dest       = '0;
        cmd_last       = 1'b0;
        axis_tx_tready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", axis_tx_tvalid, 0);
        chk("rst_tdata", axis_tx_tdata, 0);
        chk("rst_tdest", axis_tx_tdest, 0);
        chk("rst_tlast", axis_tx_tlast, 0);
        chk("rst_tid", axis_tx_tid, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cmd_rdy", cmd_rdy, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Instruction: upper payload bits must be zeroed, one-cycle extra latency.
        c      = rand_cmd();
        c.w    = 1'b0;
        c.data[31:0] = 32'h8040_2004;
        c.dest = '0;
        c.last = 1'b1;
        cycle(1'b1, c, 1'b1, acc);
        chk("instr_latency_n", axis_tx_tvalid, 0);
        cycle(1'b0, idle, 1'b1, acc);
        chk("instr_latency_n1", axis_tx_tvalid, 1);
        chk("instr_tdata", axis_tx_tdata, {75'd0, 480'd0, 32'h8040_2004});
        chk("instr_tlast", axis_tx_tlast, 1);
        cycle(1'b0, idle, 1'b1, acc);
        chk("instr_sent", sent_count, 1);
        chk("instr_idle", axis_tx_tvalid, 0);

        // Weight to DPE 2, rf_addr 5, held under stall.
        c      = rand_cmd();
        c.w    = 1'b1;
        c.data = '0;
        c.data[23:0] = 24'h010101;
        c.dpe  = 7'd2;
        c.rf   = 9'd5;
        cycle(1'b1, c, 1'b0, acc);
        cycle(1'b0, idle, 1'b0, acc);
        cycle(1'b0, idle, 1'b0, acc);
        chk("wgt_sideband", axis_tx_tdata[BW-1:DW], 75'h2605);
        chk("wgt_payload", axis_tx_tdata[DW-1:0], 512'h010101);
        drain("wgt_drain");

        // Broadcast weight.
        c     = rand_cmd();
        c.w   = 1'b1;
        c.dpe = 7'h40;
        cycle(1'b1, c, 1'b0, acc);
        cycle(1'b0, idle, 1'b0, acc);
        chk("bcast_rf_en", axis_tx_tdata[DW+74:DW+11], {64{1'b1}});
        chk("bcast_type", axis_tx_tdata[DW+10:DW+9], 2'b11);
        drain("bcast_drain");

        // Fill: 8 FIFO entries + 1 output register, then the 10th push overflows.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, rand_cmd(), 1'b0, acc);
        end
        chk("full_cmd_rdy", cmd_rdy, 0);
        chk("full_no_ovf", overflow, 0);
        cycle(1'b1, rand_cmd(), 1'b0, acc);
        chk("full_ovf", overflow, 1);
        chk("full_queued", exp_q.size(), 9);
        beats0 = n_beats;
        drain("full_drain");
        chk("full_beats", n_beats - beats0, 9);

        // Random traffic with random back-pressure.
        beats0 = n_beats;
        sent0  = n_sent;
        pushed = 0;
        guard  = 0;
        while ((pushed < 100 || exp_q.size() != 0 || axis_tx_tvalid) && guard < 5000) begin
            cycle((pushed < 100) && ($urandom_range(0, 3) != 0), rand_cmd(),
                  1'($urandom_range(0, 1)), acc);
            if (acc) pushed++;
            guard++;
        end
        chk("rand_bounded", guard < 5000, 1);
        chk("rand_beats", n_beats - beats0, 100);
        chk("rand_sent", sent_count, sent0 + 32'd100);

        // Reset mid-transfer with 3 commands queued behind a valid beat.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, rand_cmd(), 1'b0, acc);
        end
        cycle(1'b0, idle, 1'b0, acc);
        chk("prerst_tvalid", axis_tx_tvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tvalid", axis_tx_tvalid, 0);
        chk("arst_sent", sent_count, 0);
        chk("arst_cmd_rdy", cmd_rdy, 1);
        chk("arst_overflow", overflow, 0);
        chk("arst_tdata", axis_tx_tdata, 0);
        exp_q.delete();
        n_sent     = '0;
        ovf_m      = 1'b0;
        stall_prev = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        beats0 = n_beats;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, idle, 1'b1, acc);
        end
        chk("postrst_beats", n_beats - beats0, 0);
        chk("postrst_tvalid", axis_tx_tvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
